// File: rtl/mlp_neuron_mac.sv
// mlp_neuron_mac: one-neuron multiply-accumulate engine for an MLP layer.
// Streams a DEPTH-entry activation vector and the matching weight row,
// accumulates the signed products, adds a bias, shifts right and then
// saturates (or applies ReLU) into a single OUT_W result.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin one evaluation (honoured only when idle)
//   neuron_idx, bias  weight row select and signed bias, sampled on start
//   rd_en             read strobe to the activation buffer / weight memory
//   rd_addr           activation address
//   wgt_addr          weight address {neuron_idx_reg, rd_addr}
//   rd_data, wgt_data signed read data, valid one cycle after rd_en
//   busy              high whenever the engine is not idle
//   out_valid/ready   result handshake
//   out_data          signed result
//
// Build option: define MLP_RELU_EN for ReLU activation (clamp to
// [0, 2**(OUT_W-1)-1]); otherwise the result is a linear saturate.

module mlp_neuron_mac #(
  parameter int DATA_W   = 8,
  parameter int WGT_W    = 8,
  parameter int ACC_W    = 24,
  parameter int BIAS_W   = 16,
  parameter int DEPTH    = 128,
  parameter int ADDR_W   = 7,
  parameter int NEURON_W = 4,
  parameter int SHIFT    = 4,
  parameter int OUT_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NEURON_W-1:0]          neuron_idx,
  input  logic signed [BIAS_W-1:0]     bias,
  output logic                         rd_en,
  output logic [ADDR_W-1:0]            rd_addr,
  output logic [NEURON_W+ADDR_W-1:0]   wgt_addr,
  input  logic signed [DATA_W-1:0]     rd_data,
  input  logic signed [WGT_W-1:0]      wgt_data,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_W-1:0]      out_data
);

  localparam int PW = DATA_W + WGT_W;
  localparam int SW = ACC_W + 1;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);
  localparam logic signed [SW-1:0] OMAX =
    SW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [SW-1:0] OMIN =
    SW'(-(2 ** (OUT_W - 1)));

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    ACT,
    OUT
  } state_t;

  state_t                     state_q, state_d;
  logic                       rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [NEURON_W-1:0]        nidx_q, nidx_d;
  logic signed [BIAS_W-1:0]   bias_q, bias_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       dvld_q, dvld_d;
  logic                       ov_q, ov_d;
  logic signed [OUT_W-1:0]    od_q, od_d;

  logic signed [PW-1:0]       prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [SW-1:0]       acc_ext;
  logic signed [SW-1:0]       bias_ext;
  logic signed [SW-1:0]       sum;
  logic signed [SW-1:0]       shf;
  logic signed [OUT_W-1:0]    act_res;

  // Full-precision product, sign-extended to accumulator width.
  assign prod     = rd_data * wgt_data;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  // One extra bit so the bias add can never wrap.
  assign acc_ext  = {acc_q[ACC_W-1], acc_q};
  assign bias_ext = {{(SW-BIAS_W){bias_q[BIAS_W-1]}}, bias_q};
  assign sum      = acc_ext + bias_ext;
  assign shf      = sum >>> SHIFT;

`ifdef MLP_RELU_EN
  always_comb begin
    act_res = shf[OUT_W-1:0];
    unique case (1'b1)
      (shf < 0):    act_res = '0;
      (shf > OMAX): act_res = OMAX[OUT_W-1:0];
      default:      act_res = shf[OUT_W-1:0];
    endcase
  end
`else
  always_comb begin
    act_res = shf[OUT_W-1:0];
    unique case (1'b1)
      (shf < OMIN): act_res = OMIN[OUT_W-1:0];
      (shf > OMAX): act_res = OMAX[OUT_W-1:0];
      default:      act_res = shf[OUT_W-1:0];
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    rd_en_d = rd_en_q;
    addr_d  = addr_q;
    nidx_d  = nidx_q;
    bias_d  = bias_q;
    acc_d   = acc_q;
    dvld_d  = rd_en_q;
    ov_d    = ov_q;
    od_d    = od_q;

    // Read data arrives one cycle behind the strobe.
    if (dvld_q) begin
      acc_d = acc_q + prod_ext;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          nidx_d  = neuron_idx;
          bias_d  = bias;
          acc_d   = '0;
          rd_en_d = 1'b1;
          addr_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (addr_q == LAST) begin
          rd_en_d = 1'b0;
          addr_d  = '0;
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        state_d = ACT;
      end
      ACT: begin
        od_d    = act_res;
        ov_d    = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      nidx_q  <= '0;
      bias_q  <= '0;
      acc_q   <= '0;
      dvld_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      nidx_q  <= nidx_d;
      bias_q  <= bias_d;
      acc_q   <= acc_d;
      dvld_q  <= dvld_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = addr_q;
  assign wgt_addr  = {nidx_q, addr_q};
  assign busy      = (state_q != IDLE);
  assign out_valid = ov_q;
  assign out_data  = od_q;

endmodule

// File: tb/tb_mlp_neuron_mac.sv
// tb_mlp_neuron_mac: randomized scoreboard bench for mlp_neuron_mac.
// Reference model is a plain dot product + shift + clamp.

module tb_mlp_neuron_mac;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        neuron_idx;
  logic signed [15:0] bias;
  logic              rd_en;
  logic [6:0]        rd_addr;
  logic [10:0]       wgt_addr;
  logic signed [7:0] rd_data;
  logic signed [7:0] wgt_data;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data;

  always #5 clk = ~clk;

  mlp_neuron_mac dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .neuron_idx (neuron_idx),
    .bias       (bias),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .wgt_addr   (wgt_addr),
    .rd_data    (rd_data),
    .wgt_data   (wgt_data),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  logic signed [7:0] act  [128];
  logic signed [7:0] wmem [16][128];

  // Synchronous-read memories.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data  <= act[rd_addr];
      wgt_data <= wmem[wgt_addr[10:7]][wgt_addr[6:0]];
    end
  end

  int q[$];
  int passed = 0;
  int total  = 0;
  int exp_addr, exp_nidx, addr_err, rd_cnt;

  task automatic chk(string nm, int a, int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, a, e);
  endtask

  function automatic int model(int idx, int b);
    int sum, s;
    sum = b;
    for (int i = 0; i < 128; i++)
      sum += int'(act[i]) * int'(wmem[idx][i]);
    s = sum >>> 4;
`ifdef MLP_RELU_EN
    if (s < 0) s = 0;
    if (s > 127) s = 127;
`else
    if (s < -128) s = -128;
    if (s > 127) s = 127;
`endif
    return s;
  endfunction

  // Read-address tracker.
  always @(negedge clk) begin
    if (rd_en) begin
      if (rd_addr != exp_addr[6:0] ||
          wgt_addr != {exp_nidx[3:0], exp_addr[6:0]})
        addr_err++;
      exp_addr++;
      rd_cnt++;
    end
  end

  // Monitor: compare on every handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("out_data", int'(out_data), q.pop_front());
    end
  end

  task automatic fill(int a, int w, int idx);
    for (int i = 0; i < 128; i++) begin
      act[i] = 8'(a);
      wmem[idx][i] = 8'(w);
    end
  endtask

  task automatic rnd_vec(int idx, int span);
    for (int i = 0; i < 128; i++) begin
      act[i] = 8'(int'($urandom_range(0, 2*span)) - span);
      wmem[idx][i] = 8'(int'($urandom_range(0, 2*span)) - span);
    end
  endtask

  task automatic run(int idx, int b, int hold, bit stray);
    int n, d0;
    q.push_back(model(idx, b));
    exp_addr = 0; exp_nidx = idx; rd_cnt = 0; addr_err = 0;
    start = 1'b1; neuron_idx = 4'(idx); bias = 16'(b);
    @(posedge clk); #1;
    start = 1'b0;
    neuron_idx = 4'(idx) ^ 4'h6;
    bias = 16'($urandom);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
      start = (stray && n == 20);
    end
    start = 1'b0;
    chk("latency", n, 130);
    chk("rd_en_cycles", rd_cnt, 128);
    chk("addr_walk_errs", addr_err, 0);
    d0 = int'(out_data);
    for (int i = 0; i < hold; i++) begin
      start = (stray && i == 1);
      @(posedge clk); #1;
      start = 1'b0;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'(out_data), d0);
    end
    out_ready = 1'b1;
    start = stray;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    chk("accept_valid", int'(out_valid), 0);
    chk("accept_busy", int'(busy), 0);
    chk("data_kept", int'(out_data), d0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int n;
    bit hit;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    neuron_idx = '0; bias = '0;
    for (int r = 0; r < 16; r++) rnd_vec(r, 127);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_wgt_addr", int'(wgt_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);

    fill(1, 1, 0);    run(0, 0, 0, 0);
    fill(1, 1, 2);    run(2, -200, 0, 0);
    fill(16, 16, 7);  run(7, 0, 1, 0);
    fill(16, -16, 7); run(7, 0, 0, 0);
    fill(-16, 16, 9); run(9, 5000, 0, 0);

    rnd_vec(3, 20);
    run(3, 37, 5, 1);

    // Reset in the middle of a fetch.
    start = 1'b1; neuron_idx = 4'd1; bias = 16'd0;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (rd_addr != 7'd50 && n < 200) begin
      @(posedge clk); #1 n++;
    end
    hit = (rd_addr == 7'd50);
    chk("reached_addr50", int'(hit), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_rd_en", int'(rd_en), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    rnd_vec(1, 30);
    run(1, -123, 0, 0);

    for (int k = 0; k < 8; k++) begin
      int idx, span;
      idx  = int'($urandom_range(0, 15));
      span = (k % 2) ? 127 : 12;
      rnd_vec(idx, span);
      run(idx, int'($signed(16'($urandom))) >>> (k % 4),
          int'($urandom_range(0, 3)), bit'(k % 3 == 0));
    end

    repeat (3) @(posedge clk);
    #1 chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mlp_neuron_mac.md
Name: mlp_neuron_mac

Overview:
- Multiply-accumulate neuron engine downstream of a layer's ping-pong input buffer.
- On each start it streams one full DEPTH-entry activation vector out of the buffer's read port, together with the matching weight row.
- It accumulates the DEPTH signed products, adds a bias, rescales by an arithmetic shift, then applies activation and saturation.
- The single OUT_W result is presented on a valid/ready output handshake.

Parameters:
- DATA_W, 8, signed activation width
- WGT_W, 8, signed weight width
- ACC_W, 24, signed accumulator width; must be at least DATA_W+WGT_W+ADDR_W+1
- BIAS_W, 16, signed bias width
- DEPTH, 128, vector length; must equal 2**ADDR_W
- ADDR_W, 7, vector address width
- NEURON_W, 4, neuron index width
- SHIFT, 4, arithmetic right shift applied after the bias add
- OUT_W, 8, signed result width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin one neuron evaluation; honoured only in IDLE
- neuron_idx  in  NEURON_W  weight row select; sampled on start
- bias  in  BIAS_W  signed bias; sampled on start
- rd_en  out  1  read strobe to the activation buffer and the weight memory
- rd_addr  out  ADDR_W  activation read address
- wgt_addr  out  NEURON_W+ADDR_W  weight address, formed as {neuron_idx_reg, rd_addr}
- rd_data  in  DATA_W  signed activation; valid one cycle after rd_en (synchronous read)
- wgt_data  in  WGT_W  signed weight; valid one cycle after rd_en
- busy  out  1  high in every state except IDLE
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  OUT_W  signed result

Behaviour:
- Reset (synchronous, rst high at an edge):
  - state returns to IDLE from any state; any in-flight evaluation is discarded.
  - rd_en, rd_addr, wgt_addr, busy, out_valid, out_data, accumulator, data-valid pipe flag and sampled registers all go to 0.
- States: IDLE, FETCH, DRAIN, ACT, OUT.
- IDLE:
  - At start edge E0: latch neuron_idx and bias, clear the accumulator, set rd_en=1 and rd_addr=0, go to FETCH.
- FETCH:
  - rd_addr increments by 1 per edge.
  - At the edge where rd_addr==DEPTH-1: rd_en<=0, rd_addr wraps to 0, go to DRAIN.
  - rd_en is therefore high for exactly DEPTH cycles.
- Data pipe:
  - dvld is rd_en delayed by one cycle.
  - Whenever dvld=1: acc <= acc + sext(rd_data*wgt_data), using a full-precision signed product.
  - The last product is accumulated at E(DEPTH+1).
- DRAIN: one cycle wait for the final accumulate, then go to ACT.
- ACT:
  - s = (acc + sext(bias_reg)) >>> SHIFT, arithmetic shift (rounds toward minus infinity).
  - Apply activation/saturation to s (see Optional Feature).
  - Register the result into out_data, set out_valid=1, go to OUT.
  - out_valid rises at edge E(DEPTH+2); this is 130 cycles after start at default parameters.
- OUT:
  - out_valid and out_data are held stable until an edge with out_ready=1; that edge clears out_valid and returns to IDLE.
  - out_data keeps its last value after the handshake.
- start while busy=1, including the accept edge, is ignored with no queuing.
- neuron_idx and bias changes after E0 have no effect on the current evaluation.
- No intermediate wrap: the accumulator width guarantees no overflow for DEPTH products at full scale.

Optional Feature:
- Macro: MLP_RELU_EN.
- Defined: negative s gives out_data=0; s greater than 2**(OUT_W-1)-1 gives out_data=2**(OUT_W-1)-1 (127 at default).
- Undefined: linear activation; s saturates to [-2**(OUT_W-1), 2**(OUT_W-1)-1], i.e. [-128, 127] at default.
- All timing is identical in both builds.

Test Plan:
- Basic evaluation: all rd_data=1, wgt_data=1, bias=0, start pulse.
  - rd_en high exactly 128 cycles over addresses 0..127.
  - out_valid rises 130 edges after start; out_data=8 (128>>>4).
- Negative result: same stimulus with bias=-200, so s=-72>>>4=-5.
  - out_data=0 with MLP_RELU_EN.
  - out_data=-5 (0xFB) without it.
- Saturation: rd_data=16, wgt_data=16, bias=0, giving acc=32768 and s=2048.
  - out_data=127 in both builds.
  - rd_data=16, wgt_data=-16 gives out_data=-128 without MLP_RELU_EN and 0 with it.
- Weight addressing: neuron_idx=3 at start, changed to 5 one cycle later.
  - wgt_addr walks 0x180..0x1FF; the later change is ignored.
- Handshake and start gating:
  - Hold out_ready=0 for 5 cycles after out_valid; out_valid and out_data are held stable.
  - Pulse start during FETCH and during OUT; neither pulse has any effect.
  - Raise out_ready: out_valid clears next edge and busy=0.
- Reset mid-operation: assert rst while rd_addr=50 in FETCH.
  - Next edge: rd_en=0, busy=0, out_valid=0, out_data=0.
  - A fresh start then produces the correct result from a cleared accumulator.
